seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder
//  Purpose  : Watches a multiplexed, active-low 7-segment display bus, waits
//             for each (anode, segment) pair to hold still for STABLE_CYCLES
//             samples, then decodes the segment pattern back to a hex nibble
//             for that digit. Pulses frame_done once all four digits have
//             been captured since the previous pulse.
//  Config   : define SEG7_INPUT_SYNC_EN to pass seg_n/an_n through a
//             two-flop synchronizer first (adds two cycles of latency).
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  bad_pattern,
  output logic        frame_done
);

  // Dwell states
  localparam logic [1:0] c_idle  = 2'd0;  // no single digit selected
  localparam logic [1:0] c_track = 2'd1;  // valid pair, counting dwell
  localparam logic [1:0] c_held  = 2'd2;  // captured, waiting for change

  // Counter value on the edge before the one that completes the dwell
  localparam logic [15:0] c_last = 16'(STABLE_CYCLES - 1);

  logic [10:0] w_sample;       // {an_n, seg_n} as seen by the FSM
  logic [10:0] r_prev;         // previous FSM sample
  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [15:0] r_count;
  logic        w_an_valid;
  logic [1:0]  w_idx;
  logic        w_same;
  logic        w_cnt_hit;
  logic        w_capture;
  logic        w_count_load;
  logic        w_count_inc;
  logic        w_count_clear;
  logic        w_dec_hit;
  logic [3:0]  w_dec_val;
  logic        w_blank;
  logic [15:0] r_digits;
  logic [3:0]  r_valid;
  logic [3:0]  r_bad;
  logic [3:0]  r_mask;
  logic        r_frame_done;
  logic [3:0]  w_sel;
  logic [3:0]  w_mask_set;

`ifdef SEG7_INPUT_SYNC_EN
  logic [10:0] r_sync1;
  logic [10:0] r_sync2;

  // Two-flop synchronizer for the asynchronous display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {an_n, seg_n};
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = {an_n, seg_n};
`endif

  // Anode is usable only when exactly one digit is driven low
  always_comb begin
    w_an_valid = 1'b1;
    w_idx      = 2'd0;
    case (w_sample[10:7])
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_an_valid = 1'b0;
    endcase
  end

  // Inverse of the hex-to-7seg table; bit order {g,f,e,d,c,b,a}
  always_comb begin
    w_dec_hit = 1'b1;
    w_dec_val = 4'h0;
    case (w_sample[6:0])
      7'b1000000: w_dec_val = 4'h0;
      7'b1111001: w_dec_val = 4'h1;
      7'b0100100: w_dec_val = 4'h2;
      7'b0110000: w_dec_val = 4'h3;
      7'b0011001: w_dec_val = 4'h4;
      7'b0010010: w_dec_val = 4'h5;
      7'b0000010: w_dec_val = 4'h6;
      7'b1111000: w_dec_val = 4'h7;
      7'b0000000: w_dec_val = 4'h8;
      7'b0010000: w_dec_val = 4'h9;
      7'b0001000: w_dec_val = 4'hA;
      7'b0000011: w_dec_val = 4'hB;
      7'b1000110: w_dec_val = 4'hC;
      7'b0100001: w_dec_val = 4'hD;
      7'b0000110: w_dec_val = 4'hE;
      7'b0001110: w_dec_val = 4'hF;
      default:    w_dec_hit = 1'b0;
    endcase
  end

  assign w_blank   = (w_sample[6:0] == 7'b1111111);
  assign w_same    = (w_sample == r_prev);
  assign w_cnt_hit = (r_count == c_last);

  // Previous-sample register, always follows the FSM input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '1;
    else        r_prev <= w_sample;
  end

  // FSM state register; clr forces IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= c_idle;
    else if (clr) r_state <= c_idle;
    else          r_state <= w_state_next;
  end

  // Next-state logic: invalid anode always returns to IDLE
  always_comb begin
    w_state_next = r_state;
    if (!w_an_valid) begin
      w_state_next = c_idle;
    end else begin
      case (r_state)
        c_idle:  w_state_next = c_track;
        c_track: if (w_same && w_cnt_hit) w_state_next = c_held;
        c_held:  if (!w_same) w_state_next = c_track;
        default: w_state_next = c_idle;
      endcase
    end
  end

  // FSM outputs: counter controls and the capture strobe
  always_comb begin
    w_count_clear = !w_an_valid;
    w_count_load  = 1'b0;
    w_count_inc   = 1'b0;
    w_capture     = 1'b0;
    if (w_an_valid) begin
      case (r_state)
        c_idle:  w_count_load = 1'b1;
        c_track: begin
          w_count_load = !w_same;
          w_count_inc  = w_same;
          w_capture    = w_same && w_cnt_hit;
        end
        c_held:  w_count_load = !w_same;
        default: w_count_load = 1'b0;
      endcase
    end
  end

  // Dwell counter of consecutive identical samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_count <= '0;
    else if (clr)           r_count <= '0;
    else if (w_count_clear) r_count <= '0;
    else if (w_count_load)  r_count <= 16'd1;
    else if (w_count_inc)   r_count <= r_count + 16'd1;
  end

  // Captured digit data; blank and bad patterns leave the nibble untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_bad    <= '0;
    end else if (clr) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_bad    <= '0;
    end else if (w_capture) begin
      if (w_dec_hit) begin
        r_digits[{w_idx, 2'b00} +: 4] <= w_dec_val;
        r_valid[w_idx]                <= 1'b1;
        r_bad[w_idx]                  <= 1'b0;
      end else if (w_blank) begin
        r_valid[w_idx] <= 1'b0;
        r_bad[w_idx]   <= 1'b0;
      end else begin
        r_valid[w_idx] <= 1'b0;
        r_bad[w_idx]   <= 1'b1;
      end
    end
  end

  assign w_sel      = 4'b0001 << w_idx;
  assign w_mask_set = r_mask | w_sel;

  // Capture mask and frame pulse; mask clears on the completing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= '0;
      r_frame_done <= 1'b0;
    end else if (clr) begin
      r_mask       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_capture) begin
        if (&w_mask_set) begin
          r_mask       <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_mask <= w_mask_set;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign bad_pattern = r_bad;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_decoder
//  Purpose  : Self-checking bench for seg7_scan_decoder. A run-length model
//             of the display bus predicts every output each cycle; directed
//             scenarios add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

  localparam int S = 16;
`ifdef SEG7_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  bad_pattern;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int fd_count;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clr         (clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .bad_pattern (bad_pattern),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the caller 1 time unit after the n-th rising edge
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_bad, m_mask;
  logic        m_fd;
  int          m_run;
  logic [10:0] m_prev, m_d0, m_d1;

  initial begin : model
    logic [10:0] smp;
    logic [3:0]  an;
    int          idx, val;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_digits = '0; m_valid = '0; m_bad = '0; m_mask = '0; m_fd = 1'b0;
        m_run = 0; m_prev = '1; m_d0 = '1; m_d1 = '1;
      end else begin
        smp  = (LAT == 2) ? m_d1 : {an_n, seg_n};
        m_d1 = m_d0;
        m_d0 = {an_n, seg_n};
        m_fd = 1'b0;
        if (clr) begin
          m_digits = '0; m_valid = '0; m_bad = '0; m_mask = '0; m_run = 0;
        end else begin
          an = smp[10:7];
          if ($countones(~an) != 1)                m_run = 0;
          else if (m_run > 0 && smp == m_prev)     m_run = m_run + 1;
          else                                     m_run = 1;
          if (m_run == S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
            val = -1;
            for (int v = 0; v < 16; v++) if (tbl[v] == smp[6:0]) val = v;
            if (val >= 0) begin
              m_digits[idx*4 +: 4] = 4'(val);
              m_valid[idx] = 1'b1; m_bad[idx] = 1'b0;
            end else if (smp[6:0] == 7'h7F) begin
              m_valid[idx] = 1'b0; m_bad[idx] = 1'b0;
            end else begin
              m_valid[idx] = 1'b0; m_bad[idx] = 1'b1;
            end
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
              m_mask = '0;
              m_fd   = 1'b1;
            end
          end
        end
        m_prev = smp;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_digits", int'(digits), int'(m_digits));
        check("model_valid", int'(digit_valid), int'(m_valid));
        check("model_bad", int'(bad_pattern), int'(m_bad));
        check("model_frame_done", int'(frame_done), int'(m_fd));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; clr = 1'b0; an_n = 4'hF; seg_n = 7'h7F;
    wait_edges(3);
    check("reset_digits", int'(digits), 0);
    check("reset_valid", int'(digit_valid), 0);
    check("reset_bad", int'(bad_pattern), 0);
    check("reset_frame_done", int'(frame_done), 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    wait_edges(3);

    // Single digit '3' on digit 0: capture exactly at edge S+LAT
    an_n = 4'b1110; seg_n = 7'b0110000;
    wait_edges(S + LAT - 1);
    check("latency_early_valid", int'(digit_valid), 0);
    wait_edges(1);
    check("latency_digits", int'(digits[3:0]), 3);
    check("latency_valid", int'(digit_valid), 1);

    // Full scan showing 0x1A2F
    clr = 1'b1; wait_edges(1); clr = 1'b0;
    fd_count = 0;
    for (int d = 0; d < 4; d++) begin
      an_n = ~(4'b0001 << d);
      case (d)
        0: seg_n = tbl[15];
        1: seg_n = tbl[2];
        2: seg_n = tbl[10];
        default: seg_n = tbl[1];
      endcase
      repeat (20) begin wait_edges(1); if (frame_done) fd_count++; end
    end
    an_n = 4'hF;
    repeat (5) begin wait_edges(1); if (frame_done) fd_count++; end
    check("scan_digits", int'(digits), 32'h1A2F);
    check("scan_valid", int'(digit_valid), 4'hF);
    check("scan_frame_pulses", fd_count, 1);

    // Invalid anodes, then a glitching digit 2: nothing captured
    an_n = 4'b1010; seg_n = tbl[8];
    wait_edges(100);
    an_n = 4'b1111;
    wait_edges(100);
    an_n = 4'b1011;
    for (int k = 0; k < 100; k++) begin
      seg_n = (k % 10 == 9) ? 7'b1111110 : tbl[5];
      wait_edges(1);
    end
    check("noise_digits", int'(digits), 32'h1A2F);
    check("noise_valid", int'(digit_valid), 4'hF);
    check("noise_bad", int'(bad_pattern), 0);

    // Undecodable pattern on digit 1, then a good '1'
    an_n = 4'b1101; seg_n = 7'b1010101;
    wait_edges(20);
    check("bad_flag", int'(bad_pattern), 4'b0010);
    check("bad_valid", int'(digit_valid), 4'b1101);
    check("bad_digits", int'(digits), 32'h1A2F);
    seg_n = tbl[1];
    wait_edges(20);
    check("good_flag", int'(bad_pattern), 0);
    check("good_digits", int'(digits), 32'h1A1F);

    // Blank on digit 3
    an_n = 4'b0111; seg_n = 7'h7F;
    wait_edges(20);
    check("blank_valid", int'(digit_valid), 4'b0111);
    check("blank_bad", int'(bad_pattern), 0);
    check("blank_digits", int'(digits), 32'h1A1F);

    // clr on the capture edge wins
    an_n = 4'hF; wait_edges(5);
    an_n = 4'b1110; seg_n = tbl[7];
    wait_edges(S + LAT - 1);
    clr = 1'b1;
    wait_edges(1);
    check("clr_digits", int'(digits), 0);
    check("clr_valid", int'(digit_valid), 0);
    check("clr_bad", int'(bad_pattern), 0);
    check("clr_frame_done", int'(frame_done), 0);
    clr = 1'b0;
    an_n = 4'hF; wait_edges(5);

    // Reset in the middle of a dwell on digit 2
    an_n = 4'b1011; seg_n = tbl[9];
    wait_edges(8);
    rst_n = 1'b0;
    #1;
    check("midreset_digits", int'(digits), 0);
    check("midreset_valid", int'(digit_valid), 0);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(S + LAT - 1);
    check("postreset_early_valid", int'(digit_valid), 0);
    wait_edges(1);
    check("postreset_valid", int'(digit_valid), 4'b0100);
    check("postreset_digits", int'(digits), 32'h0900);

    wait_edges(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
